// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 decode stage: opcode[6:2] values, write-back and
// immediate selectors, ALU opcode bit positions and the decoded-field bundle.
package msrv32_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [2:0] WB_ALU    = 3'b000;
  localparam logic [2:0] WB_LU     = 3'b001;
  localparam logic [2:0] WB_IMM    = 3'b010;
  localparam logic [2:0] WB_IADDER = 3'b011;
  localparam logic [2:0] WB_CSR    = 3'b100;
  localparam logic [2:0] WB_PC_4   = 3'b101;

  localparam logic [2:0] IMM_R      = 3'b000;
  localparam logic [2:0] IMM_I      = 3'b001;
  localparam logic [2:0] IMM_S      = 3'b010;
  localparam logic [2:0] IMM_B      = 3'b011;
  localparam logic [2:0] IMM_U      = 3'b100;
  localparam logic [2:0] IMM_J      = 3'b101;
  localparam logic [2:0] IMM_I_LOAD = 3'b111;

  localparam int ALU_BIT_MEXT  = 4;
  localparam int ALU_BIT_ALT   = 3;
  localparam int ALU_OP_BASE_W = 5;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic [2:0]               wb_mux_sel;
    logic [2:0]               imm_type;
    logic [2:0]               csr_op;
    logic [ALU_OP_BASE_W-1:0] alu_opcode;
    logic [1:0]               load_size;
    logic                     load_unsigned;
    logic                     alu_src;
    logic                     iaddr_src;
    logic                     mem_wr_req;
    logic                     csr_wr_en;
    logic                     rf_wr_en;
    logic                     illegal;
    logic                     misaligned_load;
    logic                     misaligned_store;
  } dec_fields_t;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; byte is always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    return ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/msrv32_decode_comb.sv
// Pure combinational RV32 decode: raw instruction plus effective-address LSBs in,
// field bundle out. Legality covers opcode, funct3 and funct7 forms.
module msrv32_decode_comb
  import msrv32_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b0,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic [31:0]  instr,
  input  logic [1:0]   iadder_lsb,
  output dec_fields_t  fields
);

  logic [4:0] opc;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_load, is_store, is_op, is_op_imm, is_branch, is_jalr, is_jal;
  logic       is_lui, is_auipc, is_system, is_misc_mem, is_csr;
  logic       known_opc, shift_right_imm, op_f7_ok, imm_shift_ok, illegal;
  logic       unused_bits;

  assign opc    = instr[6:2];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  assign is_load     = (opc == OPC_LOAD);
  assign is_store    = (opc == OPC_STORE);
  assign is_op       = (opc == OPC_OP);
  assign is_op_imm   = (opc == OPC_OP_IMM);
  assign is_branch   = (opc == OPC_BRANCH);
  assign is_jalr     = (opc == OPC_JALR);
  assign is_jal      = (opc == OPC_JAL);
  assign is_lui      = (opc == OPC_LUI);
  assign is_auipc    = (opc == OPC_AUIPC);
  assign is_system   = (opc == OPC_SYSTEM);
  assign is_misc_mem = (opc == OPC_MISC_MEM);
  assign is_csr      = is_system && (funct3 != 3'b000) && ENABLE_CSR;

  assign known_opc = is_load | is_store | is_op | is_op_imm | is_branch | is_jalr |
                     is_jal | is_lui | is_auipc | is_system | is_misc_mem;

  assign shift_right_imm = is_op_imm && (funct3 == 3'b101);

  // The alternate funct7 only exists for SUB and SRA.
  always_comb begin
    op_f7_ok = 1'b0;
    if (funct7 == F7_ZERO)
      op_f7_ok = 1'b1;
    else if (funct7 == F7_ALT)
      op_f7_ok = (funct3 == 3'b000) || (funct3 == 3'b101);
    else if (funct7 == F7_MEXT)
      op_f7_ok = ENABLE_M;
  end

  always_comb begin
    imm_shift_ok = 1'b1;
    if (funct3 == 3'b001)
      imm_shift_ok = (funct7 == F7_ZERO);
    else if (funct3 == 3'b101)
      imm_shift_ok = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
  end

  always_comb begin
    illegal = 1'b0;
    if (instr[1:0] != 2'b11 || !known_opc)
      illegal = 1'b1;
    else if (is_jalr && funct3 != 3'b000)
      illegal = 1'b1;
    else if (is_branch && (funct3 == 3'b010 || funct3 == 3'b011))
      illegal = 1'b1;
    else if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
      illegal = 1'b1;
    else if (is_store && funct3 >= 3'b011)
      illegal = 1'b1;
    else if (is_op && !op_f7_ok)
      illegal = 1'b1;
    else if (is_op_imm && !imm_shift_ok)
      illegal = 1'b1;
    else if (is_system && funct3 == 3'b100)
      illegal = 1'b1;
    else if (is_system && funct3 != 3'b000 && !ENABLE_CSR)
      illegal = 1'b1;
  end

  always_comb begin
    fields = '0;

    if (is_load)                 fields.wb_mux_sel = WB_LU;
    else if (is_lui)             fields.wb_mux_sel = WB_IMM;
    else if (is_auipc)           fields.wb_mux_sel = WB_IADDER;
    else if (is_system && funct3 != 3'b000 && ENABLE_CSR)
                                 fields.wb_mux_sel = WB_CSR;
    else if (is_jal || is_jalr)  fields.wb_mux_sel = WB_PC_4;
    else                         fields.wb_mux_sel = WB_ALU;

    if (is_op)                                 fields.imm_type = IMM_R;
    else if (is_op_imm || is_misc_mem)         fields.imm_type = IMM_I;
    else if (is_store)                         fields.imm_type = IMM_S;
    else if (is_branch)                        fields.imm_type = IMM_B;
    else if (is_lui || is_auipc)               fields.imm_type = IMM_U;
    else if (is_jal)                           fields.imm_type = IMM_J;
    else if (is_load || is_jalr || is_system)  fields.imm_type = IMM_I_LOAD;
    else                                       fields.imm_type = IMM_R;

    fields.csr_op                   = funct3;
    fields.alu_opcode[2:0]          = funct3;
    fields.alu_opcode[ALU_BIT_ALT]  = funct7[5] && (is_op || shift_right_imm);
    fields.alu_opcode[ALU_BIT_MEXT] = ENABLE_M && is_op && (funct7 == F7_MEXT);

    fields.load_size     = funct3[1:0];
    fields.load_unsigned = funct3[2];
    fields.alu_src       = instr[5];
    fields.iaddr_src     = is_load | is_store | is_jalr;

    fields.misaligned_load  = is_load  && is_misaligned(funct3[1:0], iadder_lsb);
    fields.misaligned_store = is_store && is_misaligned(funct3[1:0], iadder_lsb);

    fields.illegal    = illegal;
    fields.mem_wr_req = is_store && !illegal && !fields.misaligned_store;
    fields.csr_wr_en  = is_csr && !illegal;
    fields.rf_wr_en   = (is_op | is_op_imm | is_load | is_jal | is_jalr | is_lui |
                         is_auipc | is_csr) && !illegal;
  end

endmodule

// File: rtl/msrv32_decode_stage.sv
// Registered RV32 decode stage: valid/ready handshake around the combinational
// decoder, trap flush and a saturating illegal-instruction counter.
module msrv32_decode_stage
  import msrv32_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b0,
  parameter bit ENABLE_CSR = 1'b1,
  parameter int ALU_OP_W   = 5,
  parameter int ILL_CNT_W  = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 trap_taken_in,
  input  logic                 instr_valid_in,
  output logic                 instr_ready_out,
  input  logic [31:0]          instr_in,
  input  logic [1:0]           iadder_out_1_to_0_in,
  output logic                 dec_valid_out,
  input  logic                 dec_ready_in,
  output logic [2:0]           wb_mux_sel_out,
  output logic [2:0]           imm_type_out,
  output logic [2:0]           csr_op_out,
  output logic [ALU_OP_W-1:0]  alu_opcode_out,
  output logic [1:0]           load_size_out,
  output logic                 load_unsigned_out,
  output logic                 alu_src_out,
  output logic                 iaddr_src_out,
  output logic                 mem_wr_req_out,
  output logic                 csr_wr_en_out,
  output logic                 rf_wr_en_out,
  output logic                 illegal_instr_out,
  output logic                 misaligned_load_out,
  output logic                 misaligned_store_out,
  output logic [ILL_CNT_W-1:0] illegal_count_out
);

  dec_fields_t          dec_p0;
  dec_fields_t          dec_p1;
  logic                 vld_p1;
  logic                 accept_p0;
  logic [ILL_CNT_W-1:0] ill_cnt;

  msrv32_decode_comb #(
    .ENABLE_M   (ENABLE_M),
    .ENABLE_CSR (ENABLE_CSR)
  ) u_decode_comb (
    .instr      (instr_in),
    .iadder_lsb (iadder_out_1_to_0_in),
    .fields     (dec_p0)
  );

  assign instr_ready_out = !vld_p1 || dec_ready_in;
  assign accept_p0       = instr_valid_in && instr_ready_out && !trap_taken_in;

  // p0 -> p1: trap flush wins over a same-cycle accept; a pop without accept
  // clears valid but leaves the fields as they were.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1  <= 1'b0;
      dec_p1  <= '0;
      ill_cnt <= '0;
    end else if (trap_taken_in) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1 <= 1'b1;
      dec_p1 <= dec_p0;
      if (dec_p0.illegal && ill_cnt != {ILL_CNT_W{1'b1}})
        ill_cnt <= ill_cnt + 1'b1;
    end else if (dec_ready_in) begin
      vld_p1 <= 1'b0;
    end
  end

  assign dec_valid_out        = vld_p1;
  assign wb_mux_sel_out       = dec_p1.wb_mux_sel;
  assign imm_type_out         = dec_p1.imm_type;
  assign csr_op_out           = dec_p1.csr_op;
  assign alu_opcode_out       = ALU_OP_W'(dec_p1.alu_opcode);
  assign load_size_out        = dec_p1.load_size;
  assign load_unsigned_out    = dec_p1.load_unsigned;
  assign alu_src_out          = dec_p1.alu_src;
  assign iaddr_src_out        = dec_p1.iaddr_src;
  assign mem_wr_req_out       = dec_p1.mem_wr_req;
  assign csr_wr_en_out        = dec_p1.csr_wr_en;
  assign rf_wr_en_out         = dec_p1.rf_wr_en;
  assign illegal_instr_out    = dec_p1.illegal;
  assign misaligned_load_out  = dec_p1.misaligned_load;
  assign misaligned_store_out = dec_p1.misaligned_store;
  assign illegal_count_out    = ill_cnt;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// Directed bench for msrv32_decode_stage: three instances (default, M-extension,
// 2-bit counter) share one stimulus stream.
module tb_msrv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst, trap, ivld, drdy;
  logic [31:0] instr;
  logic [1:0]  iadr;

  logic        irdy [3];
  logic        dvld [3];
  logic [2:0]  wb   [3];
  logic [2:0]  imm  [3];
  logic [2:0]  csrop[3];
  logic [4:0]  alu  [3];
  logic [1:0]  lsz  [3];
  logic        lun  [3];
  logic        asrc [3];
  logic        isrc [3];
  logic        mwr  [3];
  logic        cwr  [3];
  logic        rfw  [3];
  logic        ill  [3];
  logic        mld  [3];
  logic        mst  [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  msrv32_decode_stage #(.ENABLE_M(1'b0)) dut (
    .clk_in(clk), .rst_in(rst), .trap_taken_in(trap), .instr_valid_in(ivld),
    .instr_ready_out(irdy[0]), .instr_in(instr), .iadder_out_1_to_0_in(iadr),
    .dec_valid_out(dvld[0]), .dec_ready_in(drdy), .wb_mux_sel_out(wb[0]),
    .imm_type_out(imm[0]), .csr_op_out(csrop[0]), .alu_opcode_out(alu[0]),
    .load_size_out(lsz[0]), .load_unsigned_out(lun[0]), .alu_src_out(asrc[0]),
    .iaddr_src_out(isrc[0]), .mem_wr_req_out(mwr[0]), .csr_wr_en_out(cwr[0]),
    .rf_wr_en_out(rfw[0]), .illegal_instr_out(ill[0]), .misaligned_load_out(mld[0]),
    .misaligned_store_out(mst[0]), .illegal_count_out(cnt0));

  msrv32_decode_stage #(.ENABLE_M(1'b1)) dut_m (
    .clk_in(clk), .rst_in(rst), .trap_taken_in(trap), .instr_valid_in(ivld),
    .instr_ready_out(irdy[1]), .instr_in(instr), .iadder_out_1_to_0_in(iadr),
    .dec_valid_out(dvld[1]), .dec_ready_in(drdy), .wb_mux_sel_out(wb[1]),
    .imm_type_out(imm[1]), .csr_op_out(csrop[1]), .alu_opcode_out(alu[1]),
    .load_size_out(lsz[1]), .load_unsigned_out(lun[1]), .alu_src_out(asrc[1]),
    .iaddr_src_out(isrc[1]), .mem_wr_req_out(mwr[1]), .csr_wr_en_out(cwr[1]),
    .rf_wr_en_out(rfw[1]), .illegal_instr_out(ill[1]), .misaligned_load_out(mld[1]),
    .misaligned_store_out(mst[1]), .illegal_count_out(cnt1));

  msrv32_decode_stage #(.ILL_CNT_W(2)) dut_c2 (
    .clk_in(clk), .rst_in(rst), .trap_taken_in(trap), .instr_valid_in(ivld),
    .instr_ready_out(irdy[2]), .instr_in(instr), .iadder_out_1_to_0_in(iadr),
    .dec_valid_out(dvld[2]), .dec_ready_in(drdy), .wb_mux_sel_out(wb[2]),
    .imm_type_out(imm[2]), .csr_op_out(csrop[2]), .alu_opcode_out(alu[2]),
    .load_size_out(lsz[2]), .load_unsigned_out(lun[2]), .alu_src_out(asrc[2]),
    .iaddr_src_out(isrc[2]), .mem_wr_req_out(mwr[2]), .csr_wr_en_out(cwr[2]),
    .rf_wr_en_out(rfw[2]), .illegal_instr_out(ill[2]), .misaligned_load_out(mld[2]),
    .misaligned_store_out(mst[2]), .illegal_count_out(cnt2));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // instr, illegal, alu, wb, rf_wr, csr_wr -- decoded by the ENABLE_M=0 instance
  typedef struct {
    logic [31:0] ins;
    logic        e_ill;
    logic [4:0]  e_alu;
    logic [2:0]  e_wb;
    logic        e_rf;
    logic        e_csr;
  } vec_t;

  vec_t vecs [12] = '{
    '{32'h40000033, 1'b0, 5'b01000, 3'b000, 1'b1, 1'b0},  // SUB
    '{32'h40005033, 1'b0, 5'b01101, 3'b000, 1'b1, 1'b0},  // SRA
    '{32'h40006033, 1'b1, 5'b01110, 3'b000, 1'b0, 1'b0},  // OR with alt funct7
    '{32'h40005013, 1'b0, 5'b01101, 3'b000, 1'b1, 1'b0},  // SRAI
    '{32'h40000013, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0},  // ADDI, imm bit30 set
    '{32'h40001013, 1'b1, 5'b00001, 3'b000, 1'b0, 1'b0},  // SLLI bad funct7
    '{32'h34029073, 1'b0, 5'b00001, 3'b100, 1'b1, 1'b1},  // CSRRW
    '{32'h00004073, 1'b1, 5'b00100, 3'b100, 1'b0, 1'b0},  // SYSTEM funct3=100
    '{32'h00002063, 1'b1, 5'b00010, 3'b000, 1'b0, 1'b0},  // BRANCH funct3=010
    '{32'h000010E7, 1'b1, 5'b00001, 3'b101, 1'b0, 1'b0},  // JALR funct3=001
    '{32'h123450B7, 1'b0, 5'b00101, 3'b010, 1'b1, 1'b0},  // LUI
    '{32'h00000073, 1'b0, 5'b00000, 3'b000, 1'b0, 1'b0}   // ECALL
  };

  initial begin
    rst = 1'b1; trap = 1'b0; ivld = 1'b0; drdy = 1'b1; instr = '0; iadr = '0;
    step(); step();
    rst = 1'b0;
    check_val("rst_dvld", dvld[0], 0);
    check_val("rst_cnt", cnt0, 0);
    check_val("rst_wb", wb[0], 0);
    check_val("rst_rfw", rfw[0], 0);
    check_val("rst_irdy", irdy[0], 1);

    // ADD x1,x2,x3
    instr = 32'h003100B3; ivld = 1'b1;
    step();
    check_val("add_dvld", dvld[0], 1);
    check_val("add_wb", wb[0], 3'b000);
    check_val("add_imm", imm[0], 3'b000);
    check_val("add_alu", alu[0], 5'b00000);
    check_val("add_rfw", rfw[0], 1);
    check_val("add_ill", ill[0], 0);

    // LW x1,0(x2): misaligned at 2, aligned at 0
    instr = 32'h00012083; iadr = 2'b10;
    step();
    check_val("lw_mld", mld[0], 1);
    check_val("lw_rfw", rfw[0], 1);
    check_val("lw_wb", wb[0], 3'b001);
    check_val("lw_imm", imm[0], 3'b111);
    check_val("lw_lsz", lsz[0], 2'b10);
    iadr = 2'b00;
    step();
    check_val("lw_aligned_mld", mld[0], 0);

    // MUL x1,x1,x2
    instr = 32'h022080B3;
    step();
    check_val("mul_m_alu", alu[1], 5'b10000);
    check_val("mul_m_ill", ill[1], 0);
    check_val("mul_m_rfw", rfw[1], 1);
    check_val("mul_ill", ill[0], 1);
    check_val("mul_rfw", rfw[0], 0);
    check_val("mul_cnt", cnt0, 1);
    check_val("mul_m_cnt", cnt1, 0);

    // SW x2,0(x1) at address LSBs 01, then backpressure for 3 cycles
    instr = 32'h0020A023; iadr = 2'b01;
    step();
    drdy = 1'b0; instr = 32'h003100B3; iadr = 2'b00;
    #1;
    check_val("bp_irdy", irdy[0], 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_dvld", dvld[0], 1);
      check_val("bp_mst", mst[0], 1);
      check_val("bp_mwr", mwr[0], 0);
      check_val("bp_imm", imm[0], 3'b010);
      check_val("bp_isrc", isrc[0], 1);
      check_val("bp_irdy_hold", irdy[0], 0);
    end
    drdy = 1'b1; ivld = 1'b0;
    #1;
    check_val("pop_irdy", irdy[0], 1);
    step();
    check_val("pop_dvld", dvld[0], 0);

    // Trap coincident with an illegal instruction: dropped, counter frozen
    instr = 32'h00000000; ivld = 1'b1; trap = 1'b1;
    step();
    check_val("trap_dvld", dvld[0], 0);
    check_val("trap_cnt", cnt0, 1);
    trap = 1'b0; instr = 32'h003100B3;
    step();
    check_val("post_trap_dvld", dvld[0], 1);
    check_val("post_trap_rfw", rfw[0], 1);
    check_val("post_trap_ill", ill[0], 0);

    foreach (vecs[k]) begin
      instr = vecs[k].ins;
      step();
      check_val($sformatf("vec%0d_dvld", k), dvld[0], 1);
      check_val($sformatf("vec%0d_ill", k), ill[0], vecs[k].e_ill);
      check_val($sformatf("vec%0d_alu", k), alu[0], vecs[k].e_alu);
      check_val($sformatf("vec%0d_wb", k), wb[0], vecs[k].e_wb);
      check_val($sformatf("vec%0d_rfw", k), rfw[0], vecs[k].e_rf);
      check_val($sformatf("vec%0d_cwr", k), cwr[0], vecs[k].e_csr);
    end

    // 2-bit counter saturation, then reset mid-burst
    rst = 1'b1; ivld = 1'b0;
    step();
    rst = 1'b0;
    check_val("c2_rst_cnt", cnt2, 0);
    instr = 32'h00000000; ivld = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_val($sformatf("c2_cnt%0d", i), cnt2, (i > 3) ? 3 : i);
      check_val($sformatf("c2_ill%0d", i), ill[2], 1);
      check_val($sformatf("c2_dvld%0d", i), dvld[2], 1);
    end
    rst = 1'b1;
    step();
    check_val("c2_midrst_cnt", cnt2, 0);
    check_val("c2_midrst_dvld", dvld[2], 0);
    check_val("midrst_cnt", cnt0, 0);
    rst = 1'b0; ivld = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
